// File: rtl/isp_awb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : isp_awb_pkg                                             |
// | Description: Shared constants for the AWB statistics collector:      |
// |              statistic width, default thresholds, window defaults.   |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package isp_awb_pkg;

   localparam int STAT_W        = 32;

   localparam int LO_THRESH_DEF = 16;
   localparam int HI_THRESH_DEF = 240;

   localparam int WIN_X0_DEF    = 0;
   localparam int WIN_Y0_DEF    = 0;
   localparam int WIN_W_DEF     = 640;
   localparam int WIN_H_DEF     = 480;

endpackage
`default_nettype wire

// File: rtl/awb_sat_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : awb_sat_acc                                             |
// | Description: Unsigned accumulator that sticks at all-ones instead of |
// |              wrapping. Clear has priority over accumulate.           |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module awb_sat_acc #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] acc
);

   logic [OUT_W:0] sum;

   // One extra bit catches the carry that signals overflow
   always_comb begin
      sum = {1'b0, acc} + {{(OUT_W+1-IN_W){1'b0}}, din};
   end

   // Clear, else add with saturation on carry-out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/isp_stat_awb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : isp_stat_awb                                            |
// | Description: Per-frame white-balance statistics. Sums R/G/B and      |
// |              counts pixels that are neither dark nor clipped, then   |
// |              publishes them with a one-cycle stat_done at frame end. |
// |              Optional ROI window: define ISP_STAT_AWB_WINDOW_EN.     |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module isp_stat_awb
   import isp_awb_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int LO_THRESH = LO_THRESH_DEF,
   parameter int HI_THRESH = HI_THRESH_DEF
`ifdef ISP_STAT_AWB_WINDOW_EN
  ,parameter int WIN_X0    = WIN_X0_DEF,
   parameter int WIN_Y0    = WIN_Y0_DEF,
   parameter int WIN_W     = WIN_W_DEF,
   parameter int WIN_H     = WIN_H_DEF
`endif
)(
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              in_vsync,
   input  logic              in_href,
   input  logic [BITS-1:0]   in_r,
   input  logic [BITS-1:0]   in_g,
   input  logic [BITS-1:0]   in_b,
   output logic              stat_done,
   output logic [STAT_W-1:0] pix_cnt,
   output logic [STAT_W-1:0] sum_r,
   output logic [STAT_W-1:0] sum_g,
   output logic [STAT_W-1:0] sum_b
);

   // One extra bit so HI_THRESH = 2^BITS is representable (clip disabled)
   localparam logic [BITS:0] LO_T = (BITS+1)'(LO_THRESH);
   localparam logic [BITS:0] HI_T = (BITS+1)'(HI_THRESH);

   logic              dark;
   logic              clip;
   logic              win_ok;
   logic              qual_in;
   logic              frame_start;
   logic              frame_end;

   logic [BITS-1:0]   s1_r;
   logic [BITS-1:0]   s1_g;
   logic [BITS-1:0]   s1_b;
   logic              s1_qual;
   logic              s1_vs;
   logic              s2_vs;
   logic              vs_low_seen;

   logic              armed;
   logic [1:0]        pend;
   logic [STAT_W-1:0] acc_cnt;
   logic [STAT_W-1:0] acc_r;
   logic [STAT_W-1:0] acc_g;
   logic [STAT_W-1:0] acc_b;
   logic [STAT_W-1:0] snap_cnt;
   logic [STAT_W-1:0] snap_r;
   logic [STAT_W-1:0] snap_g;
   logic [STAT_W-1:0] snap_b;

   // Pixel qualification: reject dark, clipped and blanking pixels
   always_comb begin
      dark    = ({1'b0, in_r} < LO_T) & ({1'b0, in_g} < LO_T) & ({1'b0, in_b} < LO_T);
      clip    = ({1'b0, in_r} >= HI_T) | ({1'b0, in_g} >= HI_T) | ({1'b0, in_b} >= HI_T);
      qual_in = in_href & in_vsync & ~dark & ~clip & win_ok;
   end

   // Start needs a low vsync seen since reset, so a frame already running
   // at reset release is never armed; end is taken on the delayed vsync so
   // the last pixel has reached the accumulators.
   always_comb begin
      frame_start = in_vsync & ~s1_vs & vs_low_seen;
      frame_end   = s2_vs & ~s1_vs;
   end

`ifdef ISP_STAT_AWB_WINDOW_EN
   localparam logic [16:0] X_LO = 17'(WIN_X0);
   localparam logic [16:0] X_HI = 17'(WIN_X0 + WIN_W);
   localparam logic [16:0] Y_LO = 17'(WIN_Y0);
   localparam logic [16:0] Y_HI = 17'(WIN_Y0 + WIN_H);

   logic        href_d;
   logic [15:0] x_cnt;
   logic [15:0] y_cnt;
   logic [15:0] x_cur;

   // First pixel of a line is column 0 regardless of the stale counter
   always_comb begin
      x_cur  = (in_href & ~href_d) ? 16'd0 : x_cnt;
      win_ok = ({1'b0, x_cur} >= X_LO) && ({1'b0, x_cur} < X_HI) &&
               ({1'b0, y_cnt} >= Y_LO) && ({1'b0, y_cnt} < Y_HI);
   end

   // Column counter restarts each line, row counter advances per line end
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         href_d <= 1'b0;
         x_cnt  <= '0;
         y_cnt  <= '0;
      end else begin
         href_d <= in_href;
         if (in_href & ~href_d) begin
            x_cnt <= 16'd1;
         end else if (in_href) begin
            x_cnt <= x_cnt + 16'd1;
         end
         if (frame_start) begin
            y_cnt <= '0;
         end else if (href_d & ~in_href) begin
            y_cnt <= y_cnt + 16'd1;
         end
      end
   end
`else
   // Whole active frame is eligible
   always_comb begin
      win_ok = 1'b1;
   end
`endif

   // Stage 1 register: pixel, qualification and vsync history
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r        <= '0;
         s1_g        <= '0;
         s1_b        <= '0;
         s1_qual     <= 1'b0;
         s1_vs       <= 1'b0;
         s2_vs       <= 1'b0;
         vs_low_seen <= 1'b0;
      end else begin
         s1_r    <= in_r;
         s1_g    <= in_g;
         s1_b    <= in_b;
         s1_qual <= qual_in;
         s1_vs   <= in_vsync;
         s2_vs   <= s1_vs;
         if (!in_vsync) begin
            vs_low_seen <= 1'b1;
         end
      end
   end

   // Stage 2: saturating accumulators, cleared at frame start
   awb_sat_acc #(.IN_W(BITS), .OUT_W(STAT_W)) u_acc_r (
      .clk(pclk), .rst_n(rst_n), .clr(frame_start), .en(s1_qual), .din(s1_r), .acc(acc_r)
   );
   awb_sat_acc #(.IN_W(BITS), .OUT_W(STAT_W)) u_acc_g (
      .clk(pclk), .rst_n(rst_n), .clr(frame_start), .en(s1_qual), .din(s1_g), .acc(acc_g)
   );
   awb_sat_acc #(.IN_W(BITS), .OUT_W(STAT_W)) u_acc_b (
      .clk(pclk), .rst_n(rst_n), .clr(frame_start), .en(s1_qual), .din(s1_b), .acc(acc_b)
   );
   awb_sat_acc #(.IN_W(1), .OUT_W(STAT_W)) u_acc_cnt (
      .clk(pclk), .rst_n(rst_n), .clr(frame_start), .en(s1_qual), .din(1'b1), .acc(acc_cnt)
   );

   // Snapshot at frame end (same edge a fast restart clears the sums),
   // then delay the publish request so stat_done lands on the third edge
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         armed    <= 1'b0;
         pend     <= '0;
         snap_cnt <= '0;
         snap_r   <= '0;
         snap_g   <= '0;
         snap_b   <= '0;
      end else begin
         pend <= {pend[0], frame_end & armed & (acc_cnt != '0)};
         if (frame_end) begin
            snap_cnt <= acc_cnt;
            snap_r   <= acc_r;
            snap_g   <= acc_g;
            snap_b   <= acc_b;
         end
         if (frame_start) begin
            armed <= 1'b1;
         end else if (frame_end) begin
            armed <= 1'b0;
         end
      end
   end

   // Publish: outputs change only together with the stat_done pulse
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         stat_done <= 1'b0;
         pix_cnt   <= '0;
         sum_r     <= '0;
         sum_g     <= '0;
         sum_b     <= '0;
      end else begin
         stat_done <= pend[1];
         if (pend[1]) begin
            pix_cnt <= snap_cnt;
            sum_r   <= snap_r;
            sum_g   <= snap_g;
            sum_b   <= snap_b;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/isp_stat_awb.md
Name: isp_stat_awb

Overview:
Per-frame white-balance statistics collector on the RGB pixel stream, directly upstream of the AWB gain calculation stage. It accumulates R, G and B sums and a count over qualified pixels during each frame. At frame end it publishes pix_cnt, sum_r, sum_g and sum_b with a one-cycle stat_done pulse, which triggers the gain dividers.

Parameters:
BITS, 8, pixel component width (legal range 8..12)
LO_THRESH, 16, a pixel is excluded if all three components are below this value (dark)
HI_THRESH, 240, a pixel is excluded if any component is at or above this value (clipped)

Ports:
pclk  input  1  pixel clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
in_vsync  input  1  frame active, high for the whole frame
in_href  input  1  pixel valid
in_r  input  BITS  red component
in_g  input  BITS  green component
in_b  input  BITS  blue component
stat_done  output  1  one-cycle pulse; statistics outputs are valid
pix_cnt  output  32  number of qualified pixels in the last frame
sum_r  output  32  red sum over qualified pixels
sum_g  output  32  green sum over qualified pixels
sum_b  output  32  blue sum over qualified pixels

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-low on rst_n. Reset clears the accumulators, the pipeline, the armed flag and all outputs: stat_done=0, pix_cnt=0, sum_*=0.
- Frame detection:
  - Rising edge of in_vsync (registered previous value 0, current value 1) = frame start. It clears the accumulators and sets armed=1.
  - Falling edge of in_vsync = frame end.
  - After reset, or when reset is released mid-frame, armed=0, so the partial frame is ignored until the next rising edge.
- Pipeline:
  - S1: register inputs and compute qual = in_href & in_vsync & !dark & !clip.
    - dark = (r<LO_THRESH) & (g<LO_THRESH) & (b<LO_THRESH).
    - clip = (r>=HI_THRESH) | (g>=HI_THRESH) | (b>=HI_THRESH).
  - S2: if qual, each sum accumulates its zero-extended component and the count increments by 1.
  - in_vsync is delayed alongside the pipeline, so the last pixel of the frame is always included.
- Saturation: each 32-bit accumulator saturates at 32'hFFFFFFFF and never wraps. Accumulators saturate independently.
- Publish:
  - Frame end is detected on the delayed vsync. On the following edge, if armed=1 and count!=0, the outputs are loaded and stat_done=1 for exactly one cycle.
  - stat_done is high during the cycle that starts 3 pclk edges after the first edge sampling in_vsync=0.
  - armed is cleared on publish.
- Empty frame (count==0): no stat_done pulse and the outputs hold their previous values. This protects the downstream divider from a zero divisor.
- Outputs hold their values between pulses and are stable when stat_done is high.
- Frame restart: a new vsync rising edge that arrives within the 3-cycle drain does not corrupt the publish. The publish uses the latched accumulators, and clearing for the new frame takes effect after the latch.
- Thresholds: LO_THRESH=0 disables dark rejection. HI_THRESH=2^BITS disables clip rejection.
- in_href while in_vsync=0 is ignored.

Optional Feature:
ISP_STAT_AWB_WINDOW_EN:
- Defined:
  - Adds parameters WIN_X0, WIN_Y0, WIN_W and WIN_H.
  - An internal column counter resets on every href rising edge. A row counter increments on every href falling edge and resets at frame start.
  - qual additionally requires x in [WIN_X0, WIN_X0+WIN_W) and y in [WIN_Y0, WIN_Y0+WIN_H).
  - Counters are 16 bits.
- Undefined: no counters, and the whole active frame is eligible.
- Port list is identical in both cases.

Decomposition:
- Package isp_awb_pkg: STAT_W=32 constant, the default threshold constants, and the window default constants.
- One sub-module, awb_sat_acc:
  - Parameters IN_W and OUT_W.
  - Ports: clr, en, din, acc.
  - Implements the saturating accumulator and is instantiated four times (r, g, b, count with din=1).

Test Plan:
1. Frame of 4x4 pixels at r=100, g=120, b=80, all href -> one stat_done; pix_cnt=16, sum_r=1600, sum_g=1920, sum_b=1280.
2. Same frame with 4 pixels at (250,120,80) and 4 pixels at (5,5,5) -> pix_cnt=8, sum_r=800, sum_g=960, sum_b=640.
3. Frame where every pixel is (0,0,0) -> no stat_done; outputs keep scenario 2 values.
4. Release rst_n mid-frame (vsync already high) -> no stat_done at that frame's end; the next full frame publishes correctly.
5. Force accumulator preload near 32'hFFFFFF00, then accumulate 10 pixels at r=200 -> sum_r=32'hFFFFFFFF, no wrap.
6. Vsync falling then rising 1 cycle later with new pixels -> first frame's stats are correct, and the second frame starts from zero.
